// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write arbiter.
//   XLEN     : register data width
//   AW       : register address width
//   wr_req_t : one buffered register write {rd, data}
//   ZERO_REG : the hard-wired zero register, never written and never a hazard
package regfile_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wr_req_t;

  localparam logic [AW-1:0] ZERO_REG = '0;

endpackage

// File: rtl/regfile_wr_fifo.sv
// Photon write buffer. Entries are kept compacted with the oldest entry in
// slot 0. Each cycle the surviving entries slide down, then any push lands
// in the first free slot.
//   clk, rst_n      : clock, synchronous active-low reset
//   push, push_req  : enqueue one write (caller guarantees !full)
//   pop             : drop the head (it was written this cycle)
//   inv_en, inv_rd  : kill every valid entry whose rd matches inv_rd
//   rs1, rs2        : source addresses for the hazard match
//   head            : oldest valid entry
//   empty, full     : occupancy flags
//   count           : number of valid entries
//   match_vec       : per-slot hit of rs1/rs2 against valid, nonzero rd
module regfile_wr_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wr_req_t                push_req,
  input  logic                   pop,
  input  logic                   inv_en,
  input  logic [AW-1:0]          inv_rd,
  input  logic [AW-1:0]          rs1,
  input  logic [AW-1:0]          rs2,
  output wr_req_t                head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic [DEPTH-1:0]       match_vec
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  wr_req_t          mem_q [DEPTH];
  wr_req_t          mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [CW-1:0]    wr_idx;

  always_comb begin
    // NOTE: every variable written here is defaulted first, so no path can
    // leave one unassigned and infer a latch.
    mem_d   = mem_q;
    valid_d = '0;
    wr_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !(pop && i == 0) &&
          !(inv_en && mem_q[i].rd == inv_rd)) begin
        mem_d[wr_idx[IW-1:0]]   = mem_q[i];
        valid_d[wr_idx[IW-1:0]] = 1'b1;
        wr_idx                  = wr_idx + CW'(1);
      end
    end
    // wr_idx reaches DEPTH only when every slot survived; DEPTH is a power of
    // two, so its top bit alone flags that.
    if (push && !wr_idx[IW]) begin
      mem_d[wr_idx[IW-1:0]]   = push_req;
      valid_d[wr_idx[IW-1:0]] = 1'b1;
    end
  end

  always_comb begin
    head  = mem_q[0];
    empty = !valid_q[0];
    full  = valid_q[DEPTH-1];
    count = CW'($countones(valid_q));
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = valid_q[i] && (mem_q[i].rd != ZERO_REG) &&
                     ((mem_q[i].rd == rs1) || (mem_q[i].rd == rs2));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // NOTE: the payload array carries no reset; the valid bits alone decide
  // whether a slot means anything.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the integer register-file write port between the core writeback
// stage (zero latency) and buffered photon coprocessor writes. Photon writes
// drain into idle cycles; a starvation counter forces a drain, stalling the
// core, once the FIFO head has been denied STARVE_LIMIT times in a row.
//   clk, Rst                     : clock, synchronous active-low reset
//   core_we/core_rd/core_wdata   : writeback write request
//   mem_hold                     : suppresses the core write this cycle
//   ph_valid/ph_ready/ph_rd/...  : photon write handshake and payload
//   rs1_adr, rs2_adr             : decode sources for the hazard check
//   rf_we/rf_waddr/rf_wdata      : register-file write port
//   core_stall                   : core write lost arbitration this cycle
//   ph_hazard                    : a decode source is pending in the FIFO
//   fifo_count                   : valid FIFO entries
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   Rst,
  input  logic                   core_we,
  input  logic [AW-1:0]          core_rd,
  input  logic [XLEN-1:0]        core_wdata,
  input  logic                   mem_hold,
  input  logic                   ph_valid,
  output logic                   ph_ready,
  input  logic [AW-1:0]          ph_rd,
  input  logic [XLEN-1:0]        ph_wdata,
  input  logic [AW-1:0]          rs1_adr,
  input  logic [AW-1:0]          rs2_adr,
  output logic                   rf_we,
  output logic [AW-1:0]          rf_waddr,
  output logic [XLEN-1:0]        rf_wdata,
  output logic                   core_stall,
  output logic                   ph_hazard,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0]          starve_q, starve_d;
  wr_req_t                push_req, head;
  logic                   fifo_empty, fifo_full, fifo_push;
  logic [$clog2(DEPTH):0] count;
  logic [DEPTH-1:0]       match_vec;
  logic                   core_req, starved, grant_ph, grant_core;

  always_comb begin
    // Everything visible is qualified by Rst so outputs are quiet while reset
    // is held, even before the first reset edge clears the state.
    core_req   = Rst && core_we && (core_rd != ZERO_REG) && !mem_hold;
    starved    = (starve_q == SW'(STARVE_LIMIT));
    grant_ph   = Rst && !fifo_empty && (!core_req || starved);
    grant_core = core_req && !grant_ph;
    core_stall = core_req && grant_ph;

    // Readiness comes from the pre-edge count, so a same-cycle drain never
    // frees a slot early.
    ph_ready   = Rst && !fifo_full;
    // Writes to the zero register are handshaken and silently dropped.
    fifo_push  = ph_valid && ph_ready && (ph_rd != ZERO_REG);
    push_req.rd   = ph_rd;
    push_req.data = ph_wdata;

    rf_we    = grant_ph || grant_core;
    rf_waddr = '0;
    rf_wdata = '0;
    if (grant_ph) begin
      rf_waddr = head.rd;
      rf_wdata = head.data;
    end else if (grant_core) begin
      rf_waddr = core_rd;
      rf_wdata = core_wdata;
    end

    ph_hazard  = Rst && (|match_vec);
    fifo_count = Rst ? count : '0;

    starve_d = starve_q;
    if (fifo_empty || grant_ph) starve_d = '0;
    else if (!starved)          starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (!Rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end

  // A granted core write is younger than any buffered write to the same rd,
  // so those entries are killed rather than allowed to overwrite it later.
  regfile_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (Rst),
    .push      (fifo_push),
    .push_req  (push_req),
    .pop       (grant_ph),
    .inv_en    (grant_core),
    .inv_rd    (core_rd),
    .rs1       (rs1_adr),
    .rs2       (rs2_adr),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (count),
    .match_vec (match_vec)
  );

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: a queue-based reference model
// is compared against every output on every cycle, directed scenarios pin
// key values with literals, and a random phase follows.
module tb_regfile_wr_arbiter;

  localparam int DEPTH = 2;
  localparam int LIM   = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        Rst = 1'b0;
  logic        core_we = 1'b0, mem_hold = 1'b0, ph_valid = 1'b0;
  logic [4:0]  core_rd = '0, ph_rd = '0, rs1_adr = '0, rs2_adr = '0;
  logic [31:0] core_wdata = '0, ph_wdata = '0;
  logic        ph_ready, rf_we, core_stall, ph_hazard;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  fifo_count;

  int   n_vec = 0;
  int   n_bad = 0;
  ent_t m_q[$];
  int   m_starve = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .Rst(Rst),
    .core_we(core_we), .core_rd(core_rd), .core_wdata(core_wdata),
    .mem_hold(mem_hold),
    .ph_valid(ph_valid), .ph_ready(ph_ready), .ph_rd(ph_rd), .ph_wdata(ph_wdata),
    .rs1_adr(rs1_adr), .rs2_adr(rs2_adr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .core_stall(core_stall), .ph_hazard(ph_hazard), .fifo_count(fifo_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare all outputs against the model, then advance the model past the
  // coming rising edge.
  task automatic step();
    bit          creq, gph, gc, e_ready, e_hz;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    int          e_cnt;
    ent_t        keep[$];
    #1;
    creq    = Rst && core_we && (core_rd != 0) && !mem_hold;
    gph     = Rst && (m_q.size() != 0) && (!creq || m_starve == LIM);
    gc      = creq && !gph;
    e_ready = Rst && (m_q.size() < DEPTH);
    e_addr  = '0;
    e_data  = '0;
    if (gph) begin
      e_addr = m_q[0].rd;
      e_data = m_q[0].data;
    end else if (gc) begin
      e_addr = core_rd;
      e_data = core_wdata;
    end
    e_hz = 1'b0;
    if (Rst) foreach (m_q[k]) if (m_q[k].rd == rs1_adr || m_q[k].rd == rs2_adr) e_hz = 1'b1;
    e_cnt = Rst ? m_q.size() : 0;

    check("rf_we",      rf_we,      gph || gc);
    check("rf_waddr",   rf_waddr,   e_addr);
    check("rf_wdata",   rf_wdata,   e_data);
    check("core_stall", core_stall, creq && gph);
    check("ph_ready",   ph_ready,   e_ready);
    check("ph_hazard",  ph_hazard,  e_hz);
    check("fifo_count", fifo_count, e_cnt);

    if (!Rst) begin
      m_q.delete();
      m_starve = 0;
    end else begin
      if (m_q.size() == 0 || gph) m_starve = 0;
      else if (m_starve < LIM)    m_starve++;
      if (gph) void'(m_q.pop_front());
      if (gc) begin
        foreach (m_q[k]) if (m_q[k].rd != core_rd) keep.push_back(m_q[k]);
        m_q = keep;
      end
      if (ph_valid && e_ready && ph_rd != 0) m_q.push_back(ent_t'{ph_rd, ph_wdata});
    end
  endtask

  task automatic drv(input logic r, input logic we, input logic [4:0] crd,
                     input logic [31:0] cwd, input logic hold, input logic pv,
                     input logic [4:0] prd, input logic [31:0] pwd,
                     input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    Rst = r; core_we = we; core_rd = crd; core_wdata = cwd; mem_hold = hold;
    ph_valid = pv; ph_rd = prd; ph_wdata = pwd; rs1_adr = a1; rs2_adr = a2;
    step();
  endtask

  task automatic idle(input logic [4:0] a1);
    drv(1, 0, 0, 0, 0, 0, 0, 0, a1, 0);
  endtask

  initial begin
    // Reset
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 5, 32'h1, 0, 0);
    check("rst_ready", ph_ready, 0);

    // Idle core: photon write lands one cycle after acceptance
    drv(1, 0, 0, 0, 0, 1, 5, 32'hA5A5A5A5, 0, 0);
    check("t1_ready", ph_ready, 1);
    check("t1_no_bypass", rf_we, 0);
    idle(0);
    check("t1_count", fifo_count, 1);
    check("t1_we", rf_we, 1);
    check("t1_waddr", rf_waddr, 5);
    check("t1_wdata", rf_wdata, 32'hA5A5A5A5);
    check("t1_stall", core_stall, 0);
    idle(0);
    check("t1_empty", fifo_count, 0);

    // Busy core starves two photon writes in turn
    for (int c = 0; c <= 10; c++) begin
      drv(1, 1, 10, 32'hC0DE0000 + c, 0, c < 2, (c == 0) ? 5'd3 : 5'd4,
          (c == 0) ? 32'h33 : 32'h44, 0, 0);
      check("t2_stall", core_stall, (c == 5 || c == 10));
      if (c == 5)  check("t2_drain3", rf_waddr, 3);
      if (c == 10) check("t2_drain4", rf_waddr, 4);
    end
    idle(0);

    // Full FIFO holds off ph_ready until a dequeue edge; rd=8 pulse is lost
    for (int c = 0; c <= 9; c++) begin
      drv(1, c <= 6, 10, 32'hBEEF, 0, c <= 6,
          (c == 0) ? 5'd1 : (c == 1) ? 5'd2 : (c == 2) ? 5'd8 : 5'd6,
          32'h60 + c, 0, 0);
      if (c >= 2 && c <= 5) check("t3_not_ready", ph_ready, 0);
      if (c == 6) check("t3_ready_again", ph_ready, 1);
      if (c == 7) check("t3_drain2", rf_waddr, 2);
      if (c == 8) check("t3_drain6", rf_waddr, 6);
      if (c == 9) check("t3_no_rd8", rf_we, 0);
    end

    // Younger core write kills a pending photon write; hazard tracking
    drv(1, 1, 10, 32'h1, 0, 1, 7, 32'h11, 0, 0);
    drv(1, 1, 10, 32'h2, 0, 0, 0, 0, 0, 0);
    check("t4_hz_r0", ph_hazard, 0);
    drv(1, 1, 7, 32'h22, 0, 0, 0, 0, 7, 0);
    check("t4_hz_r7", ph_hazard, 1);
    check("t4_count1", fifo_count, 1);
    check("t4_wdata", rf_wdata, 32'h22);
    idle(7);
    check("t4_count0", fifo_count, 0);
    check("t4_hz_gone", ph_hazard, 0);
    check("t4_no_stale", rf_we, 0);

    // mem_hold suppresses the core; rd=0 photon write is dropped
    drv(1, 1, 9, 32'h99, 1, 0, 0, 0, 0, 0);
    check("t5_hold_we", rf_we, 0);
    check("t5_hold_stall", core_stall, 0);
    drv(1, 0, 0, 0, 0, 1, 0, 32'hDEAD, 0, 0);
    check("t5_r0_ready", ph_ready, 1);
    idle(0);
    check("t5_r0_count", fifo_count, 0);
    check("t5_r0_we", rf_we, 0);

    // Reset mid-operation with two entries and starve_cnt=3
    drv(1, 1, 10, 0, 0, 1, 11, 32'hB1, 0, 0);
    drv(1, 1, 10, 0, 0, 1, 12, 32'hB2, 0, 0);
    drv(1, 1, 10, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 1, 10, 0, 0, 0, 0, 0, 11, 12);
    check("t6_pre_count", fifo_count, 2);
    drv(0, 1, 10, 0, 0, 1, 13, 32'hB3, 11, 12);
    check("t6_rst_we", rf_we, 0);
    check("t6_rst_ready", ph_ready, 0);
    check("t6_rst_hz", ph_hazard, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t6_rst_count", fifo_count, 0);
    idle(11);
    check("t6_post_ready", ph_ready, 1);
    check("t6_post_we", rf_we, 0);
    check("t6_post_count", fifo_count, 0);
    idle(12);
    check("t6_post_we2", rf_we, 0);

    // Random traffic with a small address space to provoke collisions
    for (int n = 0; n < 3000; n++) begin
      drv($urandom_range(99) != 0, $urandom_range(1), 5'($urandom_range(7)),
          $urandom, $urandom_range(3) == 0, $urandom_range(1),
          5'($urandom_range(7)), $urandom,
          5'($urandom_range(7)), 5'($urandom_range(7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
